// File: rtl/trace_pkg.sv
// trace_pkg: shared constants and types for the oscilloscope trace renderer.
//   TRACE_X0 / TRACE_Y0 : top-left corner of the trace window in screen pixels
//   TRACE_W             : window width, equal to the number of samples per frame
//   TRACE_COLOR         : colour of lit trace pixels
//   GRID_COLOR          : graticule colour, used only when TRACE_GRID_EN is defined
//   cap_state_t         : capture FSM states (WAIT, CAPTURE, HOLD)
package trace_pkg;

    localparam int TRACE_X0 = 144;
    localparam int TRACE_Y0 = 172;
    localparam int TRACE_W  = 512;
    localparam int ADDR_W   = $clog2(TRACE_W);

    localparam logic [11:0] TRACE_COLOR = 12'h0F0;
    localparam logic [11:0] GRID_COLOR  = 12'h444;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port sample store, one synchronous write port and one
// synchronous read port on the same clock. A read of the address being written
// in the same cycle returns the old contents. Contents are not reset.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, rdata valid one cycle after raddr
module trace_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Write port: one sample per cycle while capturing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, so the display path sees data one cycle later.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/draw_trace.sv
// draw_trace: captures one frame of 8-bit samples during vertical blanking and
// overlays the waveform onto the incoming pixel stream, joining neighbouring
// samples with vertical segments. Every timing output and rgb_out lags its
// input by exactly two clocks.
//   clk, rst            : pixel clock, synchronous active-high reset
//   *count_in, *sync_in, *blnk_in, rgb_in : upstream timing and background colour
//   sample_valid/sample_data/sample_ready : sample stream handshake
//   freeze              : skip capture, keep showing the stored frame
//   *_out, rgb_out      : delayed timing and composited colour
// Optional build macro: TRACE_GRID_EN adds a graticule inside the window.
module draw_trace
    import trace_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        vblnk_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        sample_valid,
    input  logic [7:0]  sample_data,
    output logic        sample_ready,
    input  logic        freeze,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        vblnk_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out
);

    cap_state_t        state, state_nx;
    logic              vblnk_prev, vblnk_rise, vblnk_fall;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en, last_write;

    logic [10:0]       x0, y0;
    logic              win0;
    logic [7:0]        rd_data;

    logic [10:0]       vcount_s1, hcount_s1;
    logic              vsync_s1, hsync_s1, vblnk_s1, hblnk_s1;
    logic [11:0]       rgb_s1;
    logic              win_s1, xzero_s1;
    logic [7:0]        y_s1, prev_sample;
    logic [7:0]        row_cur, row_prev, row_lo, row_hi;
    logic              trace_on;
    logic [11:0]       base_rgb;
`ifdef TRACE_GRID_EN
    logic              grid_s1;
`endif

    assign vblnk_rise = vblnk_in && !vblnk_prev;
    assign vblnk_fall = !vblnk_in && vblnk_prev;
    assign wr_en      = sample_valid && sample_ready;
    assign last_write = wr_en && (wr_ptr == ADDR_W'(TRACE_W - 1));

    // Next-state logic. An abort (vblank ending mid-capture) lands in HOLD with
    // vblank already low, so HOLD exits on the following cycle.
    always_comb begin
        state_nx = state;
        case (state)
            WAIT:    if (vblnk_rise && !freeze)     state_nx = CAPTURE;
            CAPTURE: if (last_write || vblnk_fall)  state_nx = HOLD;
            HOLD:    if (!vblnk_in)                 state_nx = WAIT;
            default:                                state_nx = WAIT;
        endcase
    end

    // Capture registers. vblnk_prev resets high so a reset taken in the middle of
    // vblank does not count as a fresh edge and start a capture on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT;
            vblnk_prev   <= 1'b1;
            wr_ptr       <= '0;
            sample_ready <= 1'b0;
        end else begin
            state        <= state_nx;
            vblnk_prev   <= vblnk_in;
            sample_ready <= (state_nx == CAPTURE);
            if (state != CAPTURE) begin
                wr_ptr <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Stage 0: window-relative coordinates; negative offsets wrap to large
    // unsigned values and therefore fall outside the window.
    assign x0   = hcount_in - 11'(TRACE_X0);
    assign y0   = vcount_in - 11'(TRACE_Y0);
    assign win0 = (x0 < 11'(TRACE_W)) && (y0 < 11'd256);

    trace_ram #(.DEPTH(TRACE_W), .AW(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (sample_data),
        .raddr (x0[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    // Stage 1 registers: timing and per-pixel context travelling beside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            vcount_s1 <= '0;
            hcount_s1 <= '0;
            vsync_s1  <= 1'b0;
            hsync_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            hblnk_s1  <= 1'b0;
            rgb_s1    <= '0;
            win_s1    <= 1'b0;
            xzero_s1  <= 1'b0;
            y_s1      <= '0;
        end else begin
            vcount_s1 <= vcount_in;
            hcount_s1 <= hcount_in;
            vsync_s1  <= vsync_in;
            hsync_s1  <= hsync_in;
            vblnk_s1  <= vblnk_in;
            hblnk_s1  <= hblnk_in;
            rgb_s1    <= rgb_in;
            win_s1    <= win0;
            xzero_s1  <= (x0 == 11'd0);
            y_s1      <= y0[7:0];
        end
    end

`ifdef TRACE_GRID_EN
    // Graticule lines every 32 pixels, measured from the window origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            grid_s1 <= 1'b0;
        end else begin
            grid_s1 <= win0 && ((x0[4:0] == 5'd0) || (y0[4:0] == 5'd0));
        end
    end
`endif

    // The RAM word leaving stage 1 becomes the left neighbour of the next pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= '0;
        end else begin
            prev_sample <= rd_data;
        end
    end

    // Stage 1 compare: the lit span runs between this column's row and the
    // previous column's row, so steep edges draw as continuous vertical lines.
    // The first column has no left neighbour and uses its own sample.
    always_comb begin
        row_cur  = 8'd255 - rd_data;
        row_prev = 8'd255 - (xzero_s1 ? rd_data : prev_sample);
        row_lo   = (row_cur < row_prev) ? row_cur : row_prev;
        row_hi   = (row_cur < row_prev) ? row_prev : row_cur;
        trace_on = win_s1 && (y_s1 >= row_lo) && (y_s1 <= row_hi);
`ifdef TRACE_GRID_EN
        base_rgb = grid_s1 ? GRID_COLOR : rgb_s1;
`else
        base_rgb = rgb_s1;
`endif
    end

    // Stage 2 registers: final colour and the timing delayed to match it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            vcount_out <= vcount_s1;
            hcount_out <= hcount_s1;
            vsync_out  <= vsync_s1;
            hsync_out  <= hsync_s1;
            vblnk_out  <= vblnk_s1;
            hblnk_out  <= hblnk_s1;
            rgb_out    <= trace_on ? TRACE_COLOR : base_rgb;
        end
    end

endmodule

// File: tb/tb_draw_trace.sv
// tb_draw_trace: self-checking bench for draw_trace. Stimulus is driven on the
// falling edge; outputs are compared on the falling edge against expectations
// queued two cycles earlier from a sample-array model of the rendered trace.
// Honours TRACE_GRID_EN so the same bench covers both builds.
`timescale 1ns/1ps
module tb_draw_trace;

    localparam int          X0        = 144;
    localparam int          Y0        = 172;
    localparam logic [11:0] TRACE_RGB = 12'h0F0;
    localparam logic [11:0] GRID_RGB  = 12'h444;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] vcount_in = '0, hcount_in = '0;
    logic        vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b0, hblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_data = '0;
    logic        freeze = 1'b0;
    logic        sample_ready;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
    logic [11:0] rgb_out;

    always #12.5 clk = ~clk;

    draw_trace dut (
        .clk          (clk),
        .rst          (rst),
        .vcount_in    (vcount_in),
        .hcount_in    (hcount_in),
        .vsync_in     (vsync_in),
        .hsync_in     (hsync_in),
        .vblnk_in     (vblnk_in),
        .hblnk_in     (hblnk_in),
        .rgb_in       (rgb_in),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .freeze       (freeze),
        .vcount_out   (vcount_out),
        .hcount_out   (hcount_out),
        .vsync_out    (vsync_out),
        .hsync_out    (hsync_out),
        .vblnk_out    (vblnk_out),
        .hblnk_out    (hblnk_out),
        .rgb_out      (rgb_out)
    );

    typedef struct {
        logic [10:0] v, h;
        logic        vs, hs, vb, hb;
        logic [11:0] rgb;
        bit          rgb_chk;
    } exp_t;

    typedef struct {
        int          h, v;
        logic [11:0] rgb, expect_rgb;
    } vec_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          model[512];
    bit          known[512];
    logic [7:0]  frame[512];
    int          last_h = -10;
    bit          last_ok = 1'b0;
    int          hrun = 0;
    vec_t        vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One pixel clock: check what left the pipe, drive new inputs, queue their expectation.
    task automatic applyStimulus(input bit r, input int h, input int v, input bit hs, input bit vs,
                                 input bit hb, input bit vb, input logic [11:0] rgb,
                                 input bit valid, input logic [7:0] data, input bit frz,
                                 input bit tbl_en, input logic [11:0] tbl_exp);
        exp_t e, n;
        int   xi, yi, pi, ra, rb, lo, hi;
        bit   on, grid;
        @(negedge clk);
        e = exp_q.pop_front();
        checkOutput("vcount_out", 32'(vcount_out), 32'(e.v));
        checkOutput("hcount_out", 32'(hcount_out), 32'(e.h));
        checkOutput("vsync_out",  32'(vsync_out),  32'(e.vs));
        checkOutput("hsync_out",  32'(hsync_out),  32'(e.hs));
        checkOutput("vblnk_out",  32'(vblnk_out),  32'(e.vb));
        checkOutput("hblnk_out",  32'(hblnk_out),  32'(e.hb));
        if (e.rgb_chk) checkOutput("rgb_out", 32'(rgb_out), 32'(e.rgb));
        rst = r; hcount_in = 11'(h); vcount_in = 11'(v);
        hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
        sample_valid = valid; sample_data = data; freeze = frz;
        n = '{v: '0, h: '0, vs: 1'b0, hs: 1'b0, vb: 1'b0, hb: 1'b0, rgb: '0, rgb_chk: 1'b1};
        if (!r) begin
            n.v = 11'(v); n.h = 11'(h); n.vs = vs; n.hs = hs; n.vb = vb; n.hb = hb; n.rgb = rgb;
            if (h >= X0 && h < X0 + 512 && v >= Y0 && v < Y0 + 256) begin
                xi = h - X0; yi = v - Y0; pi = (xi == 0) ? 0 : xi - 1;
                n.rgb_chk = known[xi] && known[pi] && (xi == 0 || (last_ok && last_h == h - 1));
                ra = 255 - model[xi]; rb = 255 - model[pi];
                lo = (ra < rb) ? ra : rb; hi = (ra < rb) ? rb : ra;
                on = (yi >= lo) && (yi <= hi);
                grid = (xi % 32 == 0) || (yi % 32 == 0);
                if (on) n.rgb = TRACE_RGB;
`ifdef TRACE_GRID_EN
                else if (grid) n.rgb = GRID_RGB;
`endif
            end
            if (tbl_en) begin n.rgb = tbl_exp; n.rgb_chk = 1'b1; end
        end
        exp_q.push_back(n);
        last_h = h; last_ok = !r;
    endtask

    task automatic blankCycle(input bit vb, input bit valid, input bit frz);
        hrun = (hrun + 1) % 1056;
        applyStimulus(0, hrun, 610, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, vb,
                      12'($urandom), valid, 8'($urandom), frz, 0, 12'h0);
    endtask

    // Offer frame[] during one vblank; the source advances only on accepted transfers.
    task automatic captureFrame(input int abort_after, input bit frz, input bit rnd_valid, input int exp_count);
        int idx = 0, cyc = 0;
        bit v, rdy, done = 1'b0;
        logic [7:0] d;
        repeat (3) blankCycle(0, 0, frz);
        while (!done && cyc < 3000) begin
            v = rnd_valid ? ($urandom_range(3) != 0) : 1'b1;
            d = frame[idx % 512];
            hrun = (hrun + 1) % 1056;
            applyStimulus(0, hrun, 610, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'b1,
                          12'($urandom), v, d, frz, 0, 12'h0);
            rdy = sample_ready;
            checkOutput("sample_ready_capture", 32'(rdy), 32'((cyc > 0) && !frz && idx < 512));
            if (v && rdy && idx < 512) begin
                model[idx] = int'(d); known[idx] = 1'b1; idx++;
            end
            cyc++;
            if (idx == 512 || (abort_after >= 0 && idx == abort_after) || (frz && cyc == 600)) done = 1'b1;
        end
        checkOutput("transfer_count", 32'(idx), 32'(exp_count));
        if (abort_after >= 0) begin
            blankCycle(0, 0, 0);
            repeat (3) begin
                blankCycle(0, 1, 0);
                checkOutput("sample_ready_abort", 32'(sample_ready), 32'(0));
            end
        end else begin
            repeat (3) begin
                blankCycle(1, 1, 0);
                checkOutput("sample_ready_hold", 32'(sample_ready), 32'(0));
            end
            repeat (3) begin
                blankCycle(0, 1, 0);
                checkOutput("sample_ready_wait", 32'(sample_ready), 32'(0));
            end
        end
    endtask

    task automatic scanRow(input int yrow, input int xs, input int xe);
        for (int x = xs; x <= xe; x++) begin
            applyStimulus(0, X0 + x, Y0 + yrow, 1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'b0, 1'b0, 12'($urandom), 0, 8'h00, 0, 0, 12'h0);
        end
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t z;
        z = '{v: '0, h: '0, vs: 1'b0, hs: 1'b0, vb: 1'b0, hb: 1'b0, rgb: '0, rgb_chk: 1'b1};
        exp_q.push_back(z); exp_q.push_back(z);
        for (int i = 0; i < 512; i++) begin model[i] = 0; known[i] = 1'b0; end

        vecs[0]  = '{h: 144, v: 299, rgb: 12'h123, expect_rgb: 12'h0F0};
        vecs[1]  = '{h: 655, v: 299, rgb: 12'h123, expect_rgb: 12'h0F0};
        vecs[2]  = '{h: 400, v: 299, rgb: 12'hABC, expect_rgb: 12'h0F0};
        vecs[3]  = '{h: 656, v: 299, rgb: 12'hABC, expect_rgb: 12'hABC};
        vecs[4]  = '{h: 143, v: 299, rgb: 12'hABC, expect_rgb: 12'hABC};
        vecs[5]  = '{h: 300, v: 298, rgb: 12'h555, expect_rgb: 12'h555};
        vecs[6]  = '{h: 200, v: 171, rgb: 12'h321, expect_rgb: 12'h321};
        vecs[7]  = '{h: 200, v: 428, rgb: 12'h321, expect_rgb: 12'h321};
        vecs[8]  = '{h: 145, v: 299, rgb: 12'h0AA, expect_rgb: 12'h0F0};
`ifdef TRACE_GRID_EN
        vecs[9]  = '{h: 301, v: 300, rgb: 12'h666, expect_rgb: 12'h444};
        vecs[10] = '{h: 176, v: 177, rgb: 12'h777, expect_rgb: 12'h444};
        vecs[11] = '{h: 655, v: 300, rgb: 12'h0BB, expect_rgb: 12'h444};
`else
        vecs[9]  = '{h: 301, v: 300, rgb: 12'h666, expect_rgb: 12'h666};
        vecs[10] = '{h: 176, v: 177, rgb: 12'h777, expect_rgb: 12'h777};
        vecs[11] = '{h: 655, v: 300, rgb: 12'h0BB, expect_rgb: 12'h0BB};
`endif

        $display("[TB] reset");
        repeat (3) begin
            applyStimulus(1, int'($urandom_range(2047)), int'($urandom_range(2047)), 1, 1, 1, 1,
                          12'hFFF, 1, 8'hFF, 0, 0, 12'h0);
            checkOutput("sample_ready_reset", 32'(sample_ready), 32'(0));
        end
        repeat (20) begin
            applyStimulus(0, int'($urandom_range(2047)), int'($urandom_range(1023)),
                          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0,
                          12'($urandom), 0, 8'h00, 0, 0, 12'h0);
            checkOutput("sample_ready_idle", 32'(sample_ready), 32'(0));
        end

        $display("[TB] ramp capture");
        for (int i = 0; i < 512; i++) frame[i] = 8'(i);
        captureFrame(-1, 0, 0, 512);
        scanRow(0, -2, 513);
        scanRow(200, -2, 513);

        $display("[TB] flat line and vector table");
        for (int i = 0; i < 512; i++) frame[i] = 8'd128;
        captureFrame(-1, 0, 0, 512);
        scanRow(126, -2, 513);
        scanRow(127, -2, 513);
        scanRow(128, -2, 513);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, vecs[i].h - 1, vecs[i].v, 0, 0, 0, 0, 12'h000, 0, 8'h00, 0, 0, 12'h0);
            applyStimulus(0, vecs[i].h, vecs[i].v, 0, 0, 0, 0, vecs[i].rgb, 0, 8'h00, 0, 1, vecs[i].expect_rgb);
        end

        $display("[TB] step edge");
        for (int i = 0; i < 512; i++) frame[i] = (i < 256) ? 8'd0 : 8'd255;
        captureFrame(-1, 0, 1, 512);
        for (int y = 0; y < 256; y++) scanRow(y, 254, 258);

        $display("[TB] freeze");
        for (int i = 0; i < 512; i++) frame[i] = 8'($urandom);
        captureFrame(-1, 1, 1, 0);
        scanRow(0, 250, 262);
        scanRow(255, 250, 262);
        scanRow(100, -1, 513);

        $display("[TB] abort after 100 samples");
        captureFrame(100, 0, 1, 100);
        scanRow(0, -1, 513);
        scanRow(128, -1, 513);
        scanRow(255, -1, 513);

        $display("[TB] random frames");
        repeat (3) begin
            for (int i = 0; i < 512; i++) frame[i] = 8'($urandom);
            captureFrame(-1, 0, 1, 512);
            repeat (5) scanRow(int'($urandom_range(255)), -2, 513);
        end

        repeat (3) blankCycle(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_trace.md
# draw_trace

Oscilloscope trace renderer placed directly downstream of the VGA timing generator (and after the background stage) in the display pipeline. It captures one 512-sample frame of 8-bit waveform data during vertical blanking, stores it in an internal RAM, and overlays the trace onto the incoming pixel stream. Adjacent samples are joined by vertical segments so steep edges remain continuous. All timing signals are forwarded with a fixed latency matched to the colour path.

## Interface
- TRACE_X0, 144: first active column of the trace window
- TRACE_Y0, 172: first active row of the trace window
- TRACE_W, 512: window width = samples per frame (power of two)
- TRACE_COLOR, 12'h0_F_0: trace pixel colour
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  synchronous reset, active-high
- vcount_in, hcount_in  in  11  timing counts from upstream
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1  timing flags from upstream
- rgb_in  in  12  background pixel colour
- sample_valid  in  1  sample_data holds a sample
- sample_data  in  8  unsigned sample, 255 = top of window
- sample_ready  out  1  block accepts a sample this cycle
- freeze  in  1  hold the displayed frame (no capture)
- vcount_out, hcount_out  out  11  timing counts, delayed by 2
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1  timing flags, delayed by 2
- rgb_out  out  12  composited colour, delayed by 2
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.

## Operation
- Capture FSM has three states: WAIT, CAPTURE, HOLD; reset state is WAIT.
- WAIT → CAPTURE on the vblnk_in rising edge (registered compare) when freeze=0. If freeze=1, the FSM stays in WAIT.
- In CAPTURE: sample_ready=1 and wr_ptr starts at 0. Each cycle with valid&&ready writes ram[wr_ptr] and increments wr_ptr.
- After write 511, the FSM goes to HOLD and ready=0 on the following cycle.
- Abort: if vblnk_in falls while in CAPTURE, the FSM goes to HOLD. Unwritten entries keep their previous-frame data.
- HOLD → WAIT on the vblnk_in falling edge (or immediately, if entered by abort).
- sample_ready is 0 in WAIT and HOLD.
- Display datapath:
  - x = hcount_in − TRACE_X0 and y = vcount_in − TRACE_Y0, both 11-bit unsigned.
  - The window is in_win = (x < TRACE_W) && (y < 256).
  - Read address = x[8:0].
  - Sample s(x) maps to row r(x) = 255 − s(x).
- Trace pixel on when in_win && min(r(x−1), r(x)) ≤ y ≤ max(r(x−1), r(x)). At x=0, r(x−1) := r(0).
- rgb_out = TRACE_COLOR when the trace pixel is on; otherwise rgb_out = rgb_in (delayed).
- RAM contents after reset are undefined. The bench must capture a frame before checking pixels.

## Timing
- Reset values: all *_out = 0, rgb_out = 0, sample_ready = 0, wr_ptr = 0, prev-sample register = 0.
- Latency is exactly 2 cycles, in-to-out, for every timing output and rgb_out.
- Stage 0: address/window compute with synchronous RAM read issued.
- Stage 1: RAM data valid; previous-sample register updates from RAM data at the stage-1 boundary.
- Stage 2: compare result and rgb mux registered.
- Handshake: a transfer occurs on the posedge where valid&&ready=1. sample_ready is a registered output.
- Simultaneous write and read to the same address: the read returns old data. Capture only occurs in vblank, so no visible effect.
- rst asserted mid-capture: FSM returns to WAIT, wr_ptr = 0, and the partial frame is left in RAM.

## Configuration
- TRACE_GRID_EN defined: draws a graticule inside the window. A window pixel with x[4:0]==0 or y[4:0]==0 takes colour 12'h4_4_4; the trace has priority over the grid.
- TRACE_GRID_EN undefined: no grid logic is synthesised, and non-trace window pixels pass rgb_in.

## Structure
- trace_pkg contains TRACE_* defaults, the grid colour, and the FSM state enum (WAIT, CAPTURE, HOLD).
- One sub-module: trace_ram, a 512×8 simple dual-port RAM with a synchronous write port and a synchronous read port.

## Test plan
- Reset: hold rst for 3 clocks → all outputs 0, sample_ready=0; after release, *_out follows the inputs with exactly 2 cycles of delay.
- Capture: during vblank, drive valid continuously with data = i[7:0] for i = 0..511 → exactly 512 transfers; sample_ready drops on the cycle after the 512th write.
- Flat line: capture all samples = 128 → in the next frame, row TRACE_Y0+127 is TRACE_COLOR across columns 144..655; rows 126 and 128 are unmodified.
- Step edge: samples 0..255 = 0 and 256..511 = 255 → column TRACE_X0+256 is TRACE_COLOR for all 256 window rows.
- Freeze and abort:
  - freeze=1 at the vblank edge → sample_ready stays 0 and the previous frame is redisplayed.
  - Drop vblnk after 100 samples → FSM goes to HOLD; entries 100..511 keep old values.
- TRACE_GRID_EN build: pixel (TRACE_X0+32, TRACE_Y0+5) away from the trace → 12'h444; the same pixel in the non-grid build → rgb_in.
